// File: rtl/packet_switch_dma_ts_fp_arb_pkg.sv
// packet_switch_dma_ts_fp_arb_pkg: shared widths, FSM/fingerprint types and return-port decode.
package packet_switch_dma_ts_fp_arb_pkg;
  localparam int NUM_INTF_DEF = 9;
  localparam int PORTS_WIDTH = $clog2(NUM_INTF_DEF);
  localparam int FP_FLD_DEF = 32;
  localparam int SYS_FP_DEF = 20;
  typedef enum logic {IDLE, HOLD} arb_state_e;
  typedef struct packed {
    logic [FP_FLD_DEF-PORTS_WIDTH-SYS_FP_DEF-1:0] pad;
    logic [PORTS_WIDTH-1:0]                       port;
    logic [SYS_FP_DEF-1:0]                        seq;
  } ts_fp_t;
  function automatic logic [PORTS_WIDTH-1:0] fp_port(input logic [63:0] fp, input int sys_w);
    return PORTS_WIDTH'(fp >> sys_w);
  endfunction
endpackage

// File: rtl/packet_switch_dma_ts_fp_arb_rr.sv
// packet_switch_dma_ts_fp_arb_rr: round-robin arbiter; pointer moves past each winner.
module packet_switch_dma_ts_fp_arb_rr #(
  parameter  int N = 9,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);
  logic [W-1:0] ptr_q, ptr_d, off;
  logic [N-1:0] rot;
  logic [W:0]   sum;
  always_comb begin
    rot = N'({req, req} >> ptr_q);
    off = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_vld && rot[k]) begin
        gnt_vld = 1'b1;
        off = W'(k);
      end
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    gnt_idx = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
    gnt = gnt_vld ? (N'(1) << gnt_idx) : '0;
    ptr_d = !gnt_vld ? ptr_q : (gnt_idx == W'(N-1)) ? '0 : gnt_idx + W'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/packet_switch_dma_ts_fp_arb.sv
// packet_switch_dma_ts_fp_arb: shares the HSSI TX fingerprint path among requesters,
// tracking per-port credits that are returned by egress timestamps or reclaimed on timeout.
module packet_switch_dma_ts_fp_arb
  import packet_switch_dma_ts_fp_arb_pkg::*;
#(
  parameter  int NUM_INTF              = NUM_INTF_DEF,
  parameter  int FINGERPRINT_FLD_WIDTH = FP_FLD_DEF,
  parameter  int SYS_FINGERPRINT_WIDTH = SYS_FP_DEF,
  parameter  int MAX_OUTSTANDING       = 4,
  parameter  int TIMEOUT_CYC           = 4096,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1),
  localparam int AW = $clog2(TIMEOUT_CYC),
  localparam int SW = SYS_FINGERPRINT_WIDTH,
  localparam int FW = FINGERPRINT_FLD_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_INTF-1:0]          req_valid,
  output logic [NUM_INTF-1:0]          req_ready,
  output logic                         fp_tvalid,
  output logic [FW-1:0]                fp_tdata,
  input  logic                         fp_tready,
  input  logic                         ret_tvalid,
  input  logic [FW-1:0]                ret_fp,
  output logic [NUM_INTF-1:0][CW-1:0]  outstanding,
  output logic [NUM_INTF-1:0]          timeout_err,
  output logic                         ret_err
);
  arb_state_e                  state_q, state_d;
  logic [NUM_INTF-1:0]         elig, arb_req, ret_hit;
  logic [PORTS_WIDTH-1:0]      gnt_idx, ret_port;
  logic                        gnt_vld, ret_ok;
  logic [NUM_INTF-1:0][CW-1:0] out_q, out_d;
  logic [NUM_INTF-1:0][AW-1:0] age_q, age_d;
  logic [NUM_INTF-1:0][SW-1:0] seq_q, seq_d;
  logic [FW-1:0]               fp_q, fp_d;

  packet_switch_dma_ts_fp_arb_rr #(.N(NUM_INTF)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb state_d = (state_q == IDLE) ? (gnt_vld ? HOLD : IDLE) : (fp_tready ? IDLE : HOLD);
  always_comb begin
    fp_tvalid = (state_q == HOLD);
    fp_tdata = fp_q;
    outstanding = out_q;
  end

  always_comb begin
    ret_port = fp_port(64'(ret_fp), SW);
    ret_ok = ret_tvalid && (ret_port < PORTS_WIDTH'(NUM_INTF)) && (out_q[ret_port] != '0);
    ret_err = ret_tvalid && !ret_ok;
    for (int i = 0; i < NUM_INTF; i++) begin
      elig[i] = req_valid[i] && (out_q[i] < CW'(MAX_OUTSTANDING));
      ret_hit[i] = ret_ok && (ret_port == PORTS_WIDTH'(i));
      timeout_err[i] = (out_q[i] != '0) && (age_q[i] == AW'(TIMEOUT_CYC - 1)) && !ret_hit[i];
    end
    arb_req = (state_q == IDLE) ? elig : '0;
  end

  // a return on the timed-out port wins; grant and credit release on one port cancel out
  always_comb begin
    for (int i = 0; i < NUM_INTF; i++) begin
      out_d[i] = out_q[i] + CW'(req_ready[i]) - CW'(ret_hit[i] || timeout_err[i]);
      age_d[i] = (ret_hit[i] || timeout_err[i] || (req_ready[i] && out_q[i] == '0)) ? '0 :
                 (out_q[i] != '0) ? age_q[i] + AW'(1) : age_q[i];
      seq_d[i] = seq_q[i] + SW'(req_ready[i]);
    end
    fp_d = gnt_vld ? FW'({gnt_idx, seq_q[gnt_idx]}) : fp_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      age_q <= '0;
      seq_q <= '0;
      fp_q  <= '0;
    end else begin
      out_q <= out_d;
      age_q <= age_d;
      seq_q <= seq_d;
      fp_q  <= fp_d;
    end
  end
endmodule

// File: tb/tb_packet_switch_dma_ts_fp_arb.sv
// tb_packet_switch_dma_ts_fp_arb: directed and random traffic checked cycle by cycle
// against a behavioural credit/round-robin model.
module tb_packet_switch_dma_ts_fp_arb;
  localparam int NI = 9, FW = 32, SW = 4, MO = 4, TO = 16, CW = 3;
  logic                  clk = 1'b0, rst_n = 1'b1;
  logic [NI-1:0]         req_valid = '0, req_ready, timeout_err;
  logic                  fp_tvalid, fp_tready = 1'b0, ret_tvalid = 1'b0, ret_err;
  logic [FW-1:0]         fp_tdata, ret_fp = '0;
  logic [NI-1:0][CW-1:0] outstanding;

  packet_switch_dma_ts_fp_arb #(
    .NUM_INTF(NI), .FINGERPRINT_FLD_WIDTH(FW), .SYS_FINGERPRINT_WIDTH(SW),
    .MAX_OUTSTANDING(MO), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .fp_tvalid(fp_tvalid), .fp_tdata(fp_tdata), .fp_tready(fp_tready),
    .ret_tvalid(ret_tvalid), .ret_fp(ret_fp), .outstanding(outstanding),
    .timeout_err(timeout_err), .ret_err(ret_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int m_out[NI], m_age[NI], m_seq[NI], m_ptr, gidx, rport;
  bit m_hold, rok, e_rerr, obs_rerr;
  logic [FW-1:0] m_fp;
  logic [NI-1:0] e_ready, e_to, obs_ready, obs_to;
  logic [NI-1:0][CW-1:0] e_outv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_out[i] = 0; m_age[i] = 0; m_seq[i] = 0;
    end
    m_ptr = 0; m_hold = 0; m_fp = '0;
  endtask

  task automatic model_comb();
    gidx = -1;
    if (!m_hold)
      for (int k = 0; k < NI; k++) begin
        int j = (m_ptr + k) % NI;
        if (gidx < 0 && req_valid[j] && m_out[j] < MO) gidx = j;
      end
    e_ready = (gidx >= 0) ? (NI'(1) << gidx) : '0;
    rport = int'((ret_fp >> SW) & 32'hF);
    rok = ret_tvalid && rport < NI && m_out[rport] > 0;
    e_rerr = ret_tvalid && !rok;
    for (int i = 0; i < NI; i++) begin
      e_to[i] = m_out[i] > 0 && m_age[i] == TO - 1 && !(rok && rport == i);
      e_outv[i] = CW'(m_out[i]);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < NI; i++) begin
      bit g = (gidx == i);
      bit r = rok && rport == i;
      int nout = m_out[i] + int'(g) - int'(r || e_to[i]);
      m_age[i] = (r || e_to[i] || (g && m_out[i] == 0)) ? 0 : (m_out[i] > 0 ? m_age[i] + 1 : m_age[i]);
      m_out[i] = nout;
    end
    if (m_hold) begin
      if (fp_tready) m_hold = 0;
    end else if (gidx >= 0) begin
      m_hold = 1;
      m_fp = FW'((gidx << SW) | m_seq[gidx]);
      m_seq[gidx] = (m_seq[gidx] + 1) % (1 << SW);
      m_ptr = (gidx + 1) % NI;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_comb();
    check("req_ready", req_ready, e_ready);
    check("fp_tvalid", fp_tvalid, m_hold);
    check("fp_tdata", fp_tdata, m_fp);
    check("ret_err", ret_err, e_rerr);
    check("timeout_err", timeout_err, e_to);
    check("outstanding", outstanding, e_outv);
    obs_ready = req_ready; obs_to = timeout_err; obs_rerr = ret_err;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0; fp_tready = 0; ret_tvalid = 0; ret_fp = '0;
    rst_n = 0;
    #1;
    check("rst_fp_tvalid", fp_tvalid, 0);
    check("rst_outstanding", outstanding, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ng, first, p;
    bit seen;
    logic [FW-1:0] held;
    #2;
    do_reset();
    // reset while a fingerprint is pending
    req_valid = 9'h002; cycle(); req_valid = '0; cycle();
    check("t1_in_hold", fp_tvalid, 1);
    do_reset();
    req_valid = 9'h002; fp_tready = 1; cycle();
    check("t1_seq_restart", fp_tdata, 32'h10);
    // full round-robin sweep
    do_reset();
    req_valid = '1; fp_tready = 1; ng = 0;
    for (int c = 0; c < 40 && ng < 10; c++) begin
      cycle();
      if (obs_ready != 0) begin
        check("t2_order", obs_ready, NI'(1) << (ng % NI));
        check("t2_port", fp_tdata[7:4], ng % NI);
        ng++;
      end
    end
    check("t2_count", ng, 10);
    // credit exhaustion and refill
    do_reset();
    req_valid = 9'h004; fp_tready = 1; ng = 0;
    repeat (12) begin cycle(); if (obs_ready[2]) ng++; end
    check("t3_four_grants", ng, 4);
    check("t3_out2", outstanding[2], 4);
    ret_tvalid = 1; ret_fp = 32'h20; cycle(); ret_tvalid = 0;
    check("t3_blocked", obs_ready[2], 0);
    cycle();
    check("t3_fifth", obs_ready[2], 1);
    // back-pressure in HOLD
    do_reset();
    req_valid = 9'h008; cycle();
    held = fp_tdata; req_valid = '1; seen = 0;
    repeat (10) begin cycle(); seen |= |obs_ready; check("t4_stable", fp_tdata, held); end
    check("t4_no_ready", seen, 0);
    fp_tready = 1; cycle(); cycle();
    check("t4_regrant", obs_ready, 9'h010);
    // timeout, then timeout suppressed by a same-cycle return
    do_reset();
    req_valid = 9'h002; fp_tready = 1; cycle(); req_valid = '0; first = 0;
    for (int k = 1; k <= 20; k++) begin cycle(); if (obs_to[1] && first == 0) first = k; end
    check("t5_timeout_cycle", first, 16);
    check("t5_out1", outstanding[1], 0);
    req_valid = 9'h002; cycle(); req_valid = '0; seen = 0; ret_fp = 32'h10;
    for (int k = 1; k <= 18; k++) begin ret_tvalid = (k == 16); cycle(); seen |= obs_to[1]; end
    ret_tvalid = 0;
    check("t5_suppressed", seen, 0);
    check("t5_out1_ret", outstanding[1], 0);
    // bad returns and sequence wrap
    do_reset();
    ret_tvalid = 1; ret_fp = 32'h0C0; cycle();
    check("t6_bad_port", obs_rerr, 1);
    ret_fp = 32'h050; cycle();
    check("t6_zero_count", obs_rerr, 1);
    check("t6_unchanged", outstanding, 0);
    req_valid = 9'h001; fp_tready = 1; ret_fp = 32'h0; ng = 0;
    for (int c = 0; c < 60 && ng < 17; c++) begin
      cycle();
      if (obs_ready[0]) begin
        ng++;
        if (ng == 17) check("t6_seq_wrap", fp_tdata[3:0], 0);
      end
    end
    check("t6_grants", ng, 17);
    // randomized traffic
    do_reset();
    repeat (600) begin
      req_valid = NI'($urandom);
      fp_tready = ($urandom_range(0, 3) != 0);
      ret_tvalid = ($urandom_range(0, 2) == 0);
      p = $urandom_range(0, 9);
      if (p == 9) p = $urandom_range(9, 15);
      ret_fp = {24'h0, 4'(p), 4'($urandom)};
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
